// File: rtl/instr_seq_pkg.sv
// Shared types and opcode constants for the instruction issue sequencer.
package instr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } state_t;

  // Opcode occupies the top OP_W bits of every instruction word.
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b000;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return op == OP_LOAD;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small circular word buffer that can release one or two words per cycle.
module instr_fifo #(
  parameter int IW    = 11,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [IW-1:0]          push_data,
  input  logic                   pop,
  input  logic                   pop2,
  output logic [IW-1:0]          head,
  output logic [IW-1:0]          head_next,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] pop_n;

  assign pop_n     = pop2 ? CW'(2) : (pop ? CW'(1) : CW'(0));
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      // Pointer width equals log2(DEPTH), so the add wraps modulo DEPTH.
      rd_ptr <= rd_ptr + pop_n[AW-1:0];
      count  <= count + CW'(push) - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Feeds buffered instructions to the processor control circuit one at a time,
// supplies LOAD immediates on external-load, and watches for a missing Done.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int IW      = 11,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [IW-1:0] cc_instruction,
  output logic          cc_run,
  input  logic          cc_done,
  input  logic          cc_ext_load,
  output logic          busy,
  output logic          timeout_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count;
  logic [IW-1:0] head, head_next;
  logic          push, pop, pop2;
  logic          head_load, cur_load;
  logic [IW-1:0] instr_q, data_q;
  logic [WW-1:0] wd_q;

  assign in_ready = reset && !flush && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  instr_fifo #(.IW(IW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop2      (pop2),
    .head      (head),
    .head_next (head_next),
    .count     (count)
  );

  assign head_load = is_load(head[IW-1 -: OP_W]);
  assign cur_load  = is_load(instr_q[IW-1 -: OP_W]);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    pop2    = 1'b0;
    if (!flush) begin
      case (state_q)
        IDLE: begin
          // A LOAD waits in the FIFO until its data word has arrived.
          if (count != '0 && !head_load) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else if (head_load && count >= CW'(2)) begin
            pop2    = 1'b1;
            state_d = ISSUE;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (cc_done)                       state_d = IDLE;
          else if (wd_q == WW'(TIMEOUT - 1)) state_d = ERR;
        end
        ERR: state_d = ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wd_q    <= '0;
      instr_q <= '0;
      data_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      wd_q    <= '0;
      instr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ISSUE)     wd_q <= '0;
      else if (state_q == WAIT) wd_q <= wd_q + WW'(1);
      if (pop || pop2) instr_q <= head;
      if (pop2)        data_q  <= head_next;
    end
  end

  assign cc_instruction = (cc_ext_load && cur_load) ? data_q : instr_q;
  assign cc_run         = (state_q == ISSUE);
  assign busy           = (state_q != IDLE) || (count != '0);
  assign timeout_err    = (state_q == ERR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed and randomized bench for instr_sequencer against a queue-based reference model.
module tb_instr_sequencer;

  localparam int IW      = 11;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_ERR   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          cc_done = 1'b0;
  logic          cc_ext_load = 1'b0;
  logic          in_ready;
  logic [IW-1:0] cc_instruction;
  logic          cc_run;
  logic          busy;
  logic          timeout_err;

  instr_sequencer #(.IW(IW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .flush          (flush),
    .cc_instruction (cc_instruction),
    .cc_run         (cc_run),
    .cc_done        (cc_done),
    .cc_ext_load    (cc_ext_load),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a word queue plus the instruction currently owned by the control circuit.
  logic [IW-1:0] mq[$];
  int            mph;
  int            mwait;
  logic [IW-1:0] mcur;
  logic [IW-1:0] mdat;

  function automatic bit op_load(input logic [IW-1:0] w);
    return w[IW-1:IW-3] == 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    mph   = PH_IDLE;
    mwait = 0;
    mcur  = '0;
    mdat  = '0;
  endtask

  task automatic model_edge();
    bit acc;
    if (flush) begin
      model_clear();
      return;
    end
    acc = in_valid && (mq.size() < DEPTH);
    case (mph)
      PH_IDLE: begin
        if (mq.size() >= 1 && !op_load(mq[0])) begin
          mcur = mq.pop_front();
          mph  = PH_ISSUE;
        end else if (mq.size() >= 2) begin
          mcur = mq.pop_front();
          mdat = mq.pop_front();
          mph  = PH_ISSUE;
        end
      end
      PH_ISSUE: begin
        mph   = PH_WAIT;
        mwait = 0;
      end
      PH_WAIT: begin
        if (cc_done) mph = PH_IDLE;
        else begin
          mwait++;
          if (mwait == TIMEOUT) mph = PH_ERR;
        end
      end
      default: ;
    endcase
    if (acc) mq.push_back(in_data);
  endtask

  task automatic check_outputs(input string tag);
    logic [IW-1:0] exp_instr;
    exp_instr = (cc_ext_load && op_load(mcur)) ? mdat : mcur;
    chk({tag, " in_ready"}, 32'(in_ready), 32'((mq.size() < DEPTH) && !flush));
    chk({tag, " cc_run"}, 32'(cc_run), 32'(mph == PH_ISSUE));
    chk({tag, " busy"}, 32'(busy), 32'(mph != PH_IDLE || mq.size() != 0));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(mph == PH_ERR));
    chk({tag, " cc_instruction"}, 32'(cc_instruction), 32'(exp_instr));
  endtask

  // One clock: inputs are set by the caller just after a falling edge.
  task automatic cyc(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic push_word(input string tag, input logic [IW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    cyc(tag);
    in_valid = 1'b0;
  endtask

  // Answer each instruction with done after `hold` WAIT cycles until everything drains.
  task automatic serve(input string tag, input int hold);
    in_valid = 1'b0;
    for (int k = 0; k < 300 && (mph != PH_IDLE || mq.size() != 0); k++) begin
      cc_done     = (mph == PH_WAIT) && (mwait >= hold);
      cc_ext_load = (mph == PH_WAIT) && mwait[0];
      cyc(tag);
    end
    cc_done     = 1'b0;
    cc_ext_load = 1'b0;
    #1;
    chk({tag, " drained busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    model_clear();
    #2;
    chk("reset_low in_ready", 32'(in_ready), 32'(0));
    chk("reset_low cc_run", 32'(cc_run), 32'(0));
    chk("reset_low busy", 32'(busy), 32'(0));
    chk("reset_low timeout_err", 32'(timeout_err), 32'(0));
    chk("reset_low cc_instruction", 32'(cc_instruction), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    cyc("idle");
    cyc("idle");

    // Single-word instruction
    push_word("t1 push", 11'h123);
    serve("t1", 3);

    // LOAD with its data word three cycles behind
    push_word("t2 load", 11'h005);
    for (int i = 0; i < 3; i++) cyc("t2 gap");
    push_word("t2 data", 11'h7FF);
    serve("t2", 5);

    // Fill the FIFO while the control circuit is busy; the extra word is refused
    cc_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = IW'(11'h100 + i);
      cyc("t3 fill");
    end
    in_valid = 1'b0;
    serve("t3", 2);

    // Watchdog: done never comes; words keep queuing in the error state
    push_word("t4 push", 11'h2AA);
    for (int i = 0; i < 22; i++) cyc("t4 wait");
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = IW'(11'h300 + i);
      cyc("t4 err fill");
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 11'h3AA;
    cc_done  = 1'b1;
    cyc("t4 flush");
    flush    = 1'b0;
    in_valid = 1'b0;
    cc_done  = 1'b0;
    cyc("t4 after flush");

    // Done arriving on the last permitted WAIT edge wins over the watchdog
    push_word("t5 push a", 11'h444);
    push_word("t5 push b", 11'h555);
    serve("t5", TIMEOUT - 1);

    // Reset in the middle of WAIT with words queued
    for (int i = 0; i < 4; i++) push_word("t6 push", IW'(11'h600 + i));
    cyc("t6 wait");
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk("t6 reset in_ready", 32'(in_ready), 32'(0));
    chk("t6 reset cc_run", 32'(cc_run), 32'(0));
    chk("t6 reset busy", 32'(busy), 32'(0));
    chk("t6 reset timeout_err", 32'(timeout_err), 32'(0));
    chk("t6 reset cc_instruction", 32'(cc_instruction), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    cyc("t6 released");
    cyc("t6 released");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid    = ($urandom_range(0, 1) == 1);
      in_data     = ($urandom_range(0, 2) == 0) ? {3'b000, 8'($urandom)} : IW'($urandom);
      cc_done     = ($urandom_range(0, 3) == 0);
      cc_ext_load = ($urandom_range(0, 1) == 1);
      flush       = ($urandom_range(0, 59) == 0);
      cyc("rand");
    end
    in_valid    = 1'b0;
    flush       = 1'b0;
    cc_done     = 1'b0;
    cc_ext_load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction issue sequencer in front of the register/bus/ALU processor's control circuit. Buffers 11-bit instruction words from an external source in a small FIFO, presents one instruction at a time on the control circuit's `INSTRUCTION` input with a one-cycle `cc_run` start pulse, and waits for `Done`. For two-word LOAD instructions it supplies the immediate data word while the control circuit drives the external-load tri-state onto the bus. A watchdog flags a control circuit that never signals `Done`.

## Interface
- `IW`, 11, instruction/data word width (matches processor register width)
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `TIMEOUT`, 15, max cycles in WAIT before error (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `in_data`  in  IW  instruction or data word from source
- `in_valid`  in  1  source word valid
- `in_ready`  out  1  FIFO can accept; transfer when `in_valid && in_ready` at a rising edge
- `flush`  in  1  synchronous clear of FIFO, state and error
- `cc_instruction`  out  IW  word driven to control circuit `INSTRUCTION`
- `cc_run`  out  1  one-cycle start pulse
- `cc_done`  in  1  control circuit `Done`
- `cc_ext_load`  in  1  control circuit `External_load`
- `busy`  out  1  `state != IDLE || count != 0`
- `timeout_err`  out  1  sticky watchdog error

## Operation
- Opcode is `word[IW-1:IW-3]`; opcode `3'b000` = LOAD (two words: instruction, then data). All other opcodes are single-word.
- FIFO: `in_ready = (count < DEPTH) && !flush`. No pass-through when full; a simultaneous push and pop is allowed only when not full. Pointers wrap modulo DEPTH.
- States: IDLE, ISSUE, WAIT, ERR.
- IDLE: if head is non-LOAD and `count ≥ 1`, pop 1 into `instr_q` → ISSUE. If head is LOAD and `count ≥ 2`, pop both (instruction → `instr_q`, data → `data_q`) → ISSUE. If head is LOAD and `count == 1`, stay in IDLE.
- ISSUE: `cc_run = 1` for exactly this cycle → WAIT. Watchdog counter cleared.
- WAIT: `cc_done` sampled high → IDLE. Otherwise the counter increments; when the counter reaches `TIMEOUT-1` without done → ERR.
- ERR: `timeout_err = 1`; FIFO keeps accepting words until full; no issue. Only `flush` or `reset` exits ERR.
- `cc_instruction = data_q` when `cc_ext_load && current is LOAD`; otherwise `instr_q`. Held stable from ISSUE until the next pop.
- `cc_done` outside WAIT is ignored. `cc_ext_load` on a non-LOAD leaves the output at `instr_q`.
- `flush` has priority over push, pop and done: count → 0, state → IDLE, `timeout_err` → 0, `instr_q`/`data_q` → 0.

## Timing
- Reset values: `cc_instruction = 0`, `cc_run = 0`, `busy = 0`, `timeout_err = 0`, `in_ready = 1` once `reset` is high (0 while reset is low).
- Word accepted at edge k (empty FIFO, IDLE): popped at edge k+1; `cc_run` is high for the cycle between edges k+1 and k+2.
- LOAD: issue is gated on the data word having been accepted; latency is measured from acceptance of the data word.
- `cc_done` seen at edge d → IDLE at d; the next `cc_run` is no earlier than the cycle after edge d+1 (one bubble).
- Watchdog: exactly TIMEOUT WAIT cycles without done → ERR entered on the TIMEOUT-th WAIT edge. Done on that same edge wins (→ IDLE).
- Reset low mid-instruction: immediate clear; a pending control-circuit operation is abandoned (processor is reset on the same net).

## Structure
- Shared package `instr_seq_pkg`: state enum (IDLE/ISSUE/WAIT/ERR), `OP_LOAD = 3'b000`, opcode field position.
- Sub-module `instr_fifo` (parameters IW, DEPTH; ports push/pop/pop2, head, head_next, count, flush). The FSM, watchdog and output mux live in the top level.

## Test plan
- Reset then push `11'h123` (opcode 001) → `cc_run` pulse 2 cycles later with `cc_instruction = 11'h123`; hold until done; `busy` falls one cycle after done.
- Push LOAD `11'h005` then data `11'h7FF` three cycles apart → no `cc_run` until the data word is accepted; during `cc_ext_load`, `cc_instruction = 11'h7FF`, otherwise `11'h005`.
- Fill 4 words with done held low → `in_ready = 0` at count 4; a fifth `in_valid` is not accepted; returning done drains the FIFO in order.
- Withhold done for 15 WAIT cycles → `timeout_err = 1` and no further `cc_run`; `flush` → `timeout_err = 0`, count 0, IDLE.
- Done asserted on the 15th WAIT edge → no error, next instruction issued.
- Assert `reset` low during WAIT with 3 words queued → all outputs 0 asynchronously; after release, count 0 and `in_ready = 1`.
